// File: rtl/stream_demux_pkg.sv
// stream_demux_pkg: slot state encodings and counter width shared by the stream_demux files.
package stream_demux_pkg;
    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} slot_state_t;
    localparam int XFER_CNT_W = 8;
endpackage

// File: rtl/demux_slot.sv
// demux_slot: one-word holding register with a valid/ready output handshake.
module demux_slot
    import stream_demux_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             ready,
    input  logic [WIDTH-1:0] din,
    output logic             valid,
    output logic [WIDTH-1:0] data
);
    slot_state_t state, state_nxt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= EMPTY;
        else       state <= state_nxt;
    end

    // A load wins over a drain, so consume-and-reload in one cycle stays FULL.
    always_comb begin
        state_nxt = load ? FULL : (state == FULL && ready) ? EMPTY : state;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)     data <= '0;
        else if (load) data <= din;
    end

    assign valid = (state == FULL);
endmodule

// File: rtl/stream_demux.sv
// stream_demux: routes one valid/ready word stream to one of NOUT buffered channels.
// Define STREAM_DEMUX_COUNT_EN to add per-channel 8-bit handshake counters on xfer_count.
module stream_demux
    import stream_demux_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int NOUT  = 2,
    parameter int SELW  = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [SELW-1:0]       in_sel,
    input  logic [WIDTH-1:0]      in_data,
    output logic [NOUT-1:0]       out_valid,
    input  logic [NOUT-1:0]       out_ready,
    output logic [NOUT*WIDTH-1:0] out_data
`ifdef STREAM_DEMUX_COUNT_EN
    ,
    output logic [NOUT*XFER_CNT_W-1:0] xfer_count
`endif
);
    logic [NOUT-1:0] load;

    assign in_ready = !out_valid[in_sel] || out_ready[in_sel];

    for (genvar k = 0; k < NOUT; k++) begin : g_slot
        assign load[k] = in_valid && in_ready && (in_sel == SELW'(k));
        demux_slot #(.WIDTH(WIDTH)) u_slot (
            .clk   (clk),
            .reset (reset),
            .load  (load[k]),
            .ready (out_ready[k]),
            .din   (in_data),
            .valid (out_valid[k]),
            .data  (out_data[k*WIDTH +: WIDTH])
        );
    end

`ifdef STREAM_DEMUX_COUNT_EN
    logic [XFER_CNT_W-1:0] cnt [NOUT];

    always_ff @(posedge clk or posedge reset) begin
        for (int i = 0; i < NOUT; i++) begin
            if (reset)        cnt[i] <= '0;
            else if (load[i]) cnt[i] <= cnt[i] + 1'b1;
        end
    end

    for (genvar k = 0; k < NOUT; k++) begin : g_cnt
        assign xfer_count[k*XFER_CNT_W +: XFER_CNT_W] = cnt[k];
    end
`endif
endmodule

// File: tb/tb_stream_demux.sv
// tb_stream_demux: directed self-checking bench for stream_demux (NOUT=4 when STREAM_DEMUX_COUNT_EN is defined).
module tb_stream_demux;
    localparam int W = 8;
`ifdef STREAM_DEMUX_COUNT_EN
    localparam int N = 4;
    localparam int SW = 2;
`else
    localparam int N = 2;
    localparam int SW = 1;
`endif

    logic            clk = 0;
    logic            reset = 0;
    logic            in_valid = 0;
    logic            in_ready;
    logic [SW-1:0]   in_sel = '0;
    logic [W-1:0]    in_data = '0;
    logic [N-1:0]    out_valid;
    logic [N-1:0]    out_ready = '0;
    logic [N*W-1:0]  out_data;
`ifdef STREAM_DEMUX_COUNT_EN
    logic [N*8-1:0]  xfer_count;
`endif
    int checks = 0;
    int passed = 0;

    always #5 clk = ~clk;

    stream_demux #(.WIDTH(W), .NOUT(N), .SELW(SW)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_sel    (in_sel),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
`ifdef STREAM_DEMUX_COUNT_EN
        ,
        .xfer_count(xfer_count)
`endif
    );

    function automatic logic [W-1:0] ch(input int k);
        return out_data[k*W +: W];
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1; in_valid = 1; in_sel = '0; in_data = 8'hFF; out_ready = '0;
        step(); step();
        checks++; if (out_valid !== N'(0)) $display("FAIL rst_valid: got %b expected 0", out_valid); else passed++;
        checks++; if (out_data !== '0) $display("FAIL rst_data: got %h expected 0", out_data); else passed++;
        in_valid = 0;
        reset = 0;
        step();
        checks++; if (out_valid !== N'(0)) $display("FAIL rel_noload: got %b expected 0", out_valid); else passed++;
        checks++; if (in_ready !== 1'b1) $display("FAIL rel_ready: got %b expected 1", in_ready); else passed++;
        in_valid = 1;
        step();
        checks++; if (out_valid !== N'(1)) $display("FAIL rel_load_v: got %b expected 1", out_valid); else passed++;
        checks++; if (ch(0) !== 8'hFF) $display("FAIL rel_load_d: got %h expected ff", ch(0)); else passed++;
        in_valid = 0; out_ready = '1;
        step();
        checks++; if (out_valid !== N'(0)) $display("FAIL drain_v: got %b expected 0", out_valid); else passed++;
        checks++; if (ch(0) !== 8'hFF) $display("FAIL drain_hold: got %h expected ff", ch(0)); else passed++;
    endtask

    task automatic test_route();
        out_ready = '1; in_valid = 1; in_sel = SW'(0); in_data = 8'hA5;
        step();
        checks++; if (out_valid !== N'(1)) $display("FAIL route0_v: got %b expected 01", out_valid); else passed++;
        checks++; if (ch(0) !== 8'hA5) $display("FAIL route0_d: got %h expected a5", ch(0)); else passed++;
        in_sel = SW'(1); in_data = 8'h3C;
        step();
        checks++; if (out_valid !== N'(2)) $display("FAIL route1_v: got %b expected 10", out_valid); else passed++;
        checks++; if (ch(1) !== 8'h3C) $display("FAIL route1_d: got %h expected 3c", ch(1)); else passed++;
        in_valid = 0;
        step();
        checks++; if (out_valid !== N'(0)) $display("FAIL route_idle: got %b expected 0", out_valid); else passed++;
    endtask

    task automatic test_backpressure();
        out_ready = '0; in_valid = 1; in_sel = SW'(0); in_data = 8'h11;
        step();
        checks++; if (ch(0) !== 8'h11) $display("FAIL bp_first: got %h expected 11", ch(0)); else passed++;
        in_data = 8'h22;
        #1;
        checks++; if (in_ready !== 1'b0) $display("FAIL bp_stall: got %b expected 0", in_ready); else passed++;
        step();
        checks++; if (ch(0) !== 8'h11) $display("FAIL bp_hold: got %h expected 11", ch(0)); else passed++;
        checks++; if (out_valid !== N'(1)) $display("FAIL bp_hold_v: got %b expected 01", out_valid); else passed++;
        out_ready[0] = 1;
        #1;
        checks++; if (in_ready !== 1'b1) $display("FAIL bp_pass: got %b expected 1", in_ready); else passed++;
        step();
        checks++; if (ch(0) !== 8'h22) $display("FAIL bp_reload: got %h expected 22", ch(0)); else passed++;
        checks++; if (out_valid !== N'(1)) $display("FAIL bp_reload_v: got %b expected 01", out_valid); else passed++;
        in_valid = 0;
        step();
        checks++; if (out_valid !== N'(0)) $display("FAIL bp_empty: got %b expected 0", out_valid); else passed++;
    endtask

    task automatic test_isolation();
        out_ready = '0; in_valid = 1; in_sel = SW'(0); in_data = 8'h55;
        step();
        in_sel = SW'(1); in_data = 8'h77;
        #1;
        checks++; if (in_ready !== 1'b1) $display("FAIL iso_ready: got %b expected 1", in_ready); else passed++;
        step();
        checks++; if (out_valid !== N'(3)) $display("FAIL iso_v: got %b expected 11", out_valid); else passed++;
        checks++; if (ch(0) !== 8'h55) $display("FAIL iso_ch0: got %h expected 55", ch(0)); else passed++;
        checks++; if (ch(1) !== 8'h77) $display("FAIL iso_ch1: got %h expected 77", ch(1)); else passed++;
        in_valid = 0; in_sel = SW'(0); in_data = 8'h99; out_ready[0] = 1;
        step();
        checks++; if (ch(0) !== 8'h55) $display("FAIL idle_noload: got %h expected 55", ch(0)); else passed++;
        checks++; if (out_valid !== N'(2)) $display("FAIL idle_v: got %b expected 10", out_valid); else passed++;
        out_ready = '0; in_valid = 1; in_data = 8'h66;
        step();
        in_valid = 0;
        checks++; if (out_valid !== N'(3)) $display("FAIL refill_v: got %b expected 11", out_valid); else passed++;
    endtask

    task automatic test_reset_mid();
        reset = 1;
        #1;
        checks++; if (out_valid !== N'(0)) $display("FAIL async_v: got %b expected 0", out_valid); else passed++;
        checks++; if (out_data !== '0) $display("FAIL async_d: got %h expected 0", out_data); else passed++;
        #1 reset = 0;
        step();
        checks++; if (out_valid !== N'(0)) $display("FAIL post_rst_v: got %b expected 0", out_valid); else passed++;
    endtask

`ifdef STREAM_DEMUX_COUNT_EN
    task automatic test_count();
        checks++; if (xfer_count !== '0) $display("FAIL cnt_rst: got %h expected 0", xfer_count); else passed++;
        out_ready = '1; in_valid = 1; in_sel = SW'(2);
        for (int i = 0; i < 258; i++) begin
            in_data = W'(i);
            step();
            if (i == 0) begin
                checks++; if (xfer_count !== 32'h0001_0000) $display("FAIL cnt_first: got %h expected 00010000", xfer_count); else passed++;
            end
        end
        in_valid = 0;
        step();
        checks++; if (xfer_count !== 32'h0002_0000) $display("FAIL cnt_wrap: got %h expected 00020000", xfer_count); else passed++;
        checks++; if (ch(2) !== 8'h01) $display("FAIL cnt_last: got %h expected 01", ch(2)); else passed++;
    endtask
`endif

    initial begin
        #1;
        test_reset();
        test_route();
        test_backpressure();
        test_isolation();
        test_reset_mid();
`ifdef STREAM_DEMUX_COUNT_EN
        test_count();
`endif
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
